// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, sequencer states and
// the command record carried through the command FIFO.
package alu_ctrl_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_XNOR = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_NAND = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    typedef struct packed {
        logic             use_acc;
        logic [2:0]       sel;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU driven by the command sequencer; results wrap modulo 2^W.
module alu
    import alu_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_XOR:  y = a ^ b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra MSB so full and empty
// can be told apart when the index bits match.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: queues commands, drives one onto the
// ALU every other cycle and registers the result for a downstream consumer.
module alu_cmd_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_sel,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_use_acc,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [W-1:0] alu_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [2:0]   res_sel,
    output logic         res_zero
);

    localparam int CMD_W = 1 + 3 + 2 * W;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // a source keeps valid and its payload steady until that edge.
    state_t           state;
    logic [W-1:0]     acc;
    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             head_use_acc;
    logic [2:0]       head_sel;
    logic [W-1:0]     head_a;
    logic [W-1:0]     head_b;

    assign fifo_wdata = {in_use_acc, in_sel, in_a, in_b};
    assign {head_use_acc, head_sel, head_a, head_b} = fifo_rdata;

    assign in_ready = !fifo_full && !rst;
    assign push     = in_valid && in_ready;
    // Issue only when the result register will be free at the capture edge.
    assign pop      = (state == ST_IDLE) && !fifo_empty && (!res_valid || res_ready);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
            res_zero  <= 1'b0;
        end else begin
            if (res_valid && res_ready) res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        alu_sel <= head_sel;
                        alu_b   <= head_b;
                        alu_a   <= head_use_acc ? acc : head_a;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A capture overrides the consume-clear above.
                    res_data  <= alu_y;
                    acc       <= alu_y;
                    res_sel   <= alu_sel;
                    res_zero  <= (alu_y == '0);
                    res_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer driving a real alu instance,
// scored against an in-order arithmetic model of the command stream.
module tb_alu_cmd_sequencer;
    import alu_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_sel;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_use_acc;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_y;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [2:0]   res_sel;
    logic         res_zero;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_acc (in_use_acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_y      (alu_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_sel    (res_sel),
        .res_zero   (res_zero)
    );

    alu #(.W(W)) u_alu (
        .sel (alu_sel),
        .a   (alu_a),
        .b   (alu_b),
        .y   (alu_y)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    logic [2:0]   sel_q[$];
    logic [W-1:0] acc_m;
    int           res_cyc_log[$];
    int           cyc = 0;
    bit           rand_rdy = 0;

    function automatic logic [W-1:0] ref_op(input logic [2:0] s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int m = 1 << W;
        int ai = int'(a);
        int bi = int'(b);
        int r;
        logic [31:0] rv;
        case (s)
            OP_ADD:  r = (ai + bi) % m;
            OP_SUB:  r = (ai - bi + m) % m;
            OP_AND:  r = ai & bi;
            OP_NOR:  r = ~(ai | bi) & (m - 1);
            OP_XNOR: r = ~(ai ^ bi) & (m - 1);
            OP_XOR:  r = ai ^ bi;
            OP_OR:   r = ai | bi;
            default: r = ~(ai & bi) & (m - 1);
        endcase
        rv = r;
        return rv[W-1:0];
    endfunction

    // Results come back in acceptance order and each one feeds the next use_acc.
    task automatic model_push(input logic ua, input logic [2:0] s, input logic [W-1:0] a,
                              input logic [W-1:0] b);
        logic [W-1:0] r;
        r = ref_op(s, ua ? acc_m : a, b);
        acc_m = r;
        exp_q.push_back(r);
        sel_q.push_back(s);
    endtask

    // ---------------- scoreboard monitor ----------------
    bit           hold_prev = 0;
    logic [W-1:0] hold_data;
    logic [2:0]   hold_sel;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            sel_q.delete();
        end else begin
            if (res_valid && hold_prev) begin
                check("hold_data", res_data, hold_data);
                check("hold_sel", res_sel, hold_sel);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", res_data, 32'hdead);
                end else begin
                    logic [W-1:0] e;
                    logic [2:0]   s;
                    e = exp_q.pop_front();
                    s = sel_q.pop_front();
                    check("res_data", res_data, e);
                    check("res_sel", res_sel, s);
                    check("res_zero", res_zero, (e == '0));
                    res_cyc_log.push_back(cyc);
                end
            end
        end
        hold_prev = !rst && res_valid && !res_ready;
        hold_data = res_data;
        hold_sel  = res_sel;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        acc_m = '0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic ua, input logic [2:0] s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        int  budget = 0;
        bit  ok = 0;
        in_valid = 1'b1;
        in_use_acc = ua;
        in_sel = s;
        in_a = a;
        in_b = b;
        while (!ok && budget < 400) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else begin
                budget++;
                tick();
            end
        end
        if (ok) begin
            model_push(ua, s, a, b);
            tick();
        end else begin
            check("in_ready_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while ((exp_q.size() != 0 || res_valid) && budget < 2000) begin
            tick();
            budget++;
        end
        check("drain_timeout", (budget < 2000), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_seen;
        int base;
        cmd_t c;
        logic [2:0] ops [8];

        rst = 1'b1;
        in_valid = 1'b0;
        in_sel = '0;
        in_a = '0;
        in_b = '0;
        in_use_acc = 1'b0;
        res_ready = 1'b0;
        acc_m = '0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_sel", res_sel, 0);
        check("rst_res_zero", res_zero, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        tick();

        // 1: single ADD with latency check
        res_ready = 1'b1;
        send(1'b0, OP_ADD, 4'd4, 4'd2);
        @(negedge clk);
        @(negedge clk);
        check("lat_e1_valid", res_valid, 0);
        @(negedge clk);
        check("lat_e2_valid", res_valid, 1);
        drain();

        // 2: SUB wrap, XOR zero
        send(1'b0, OP_SUB, 4'd2, 4'd4);
        send(1'b0, OP_XOR, 4'd5, 4'd5);
        drain();

        // 3: accumulate chain, consumer ready then stalled
        for (int pass = 0; pass < 2; pass++) begin
            res_ready = (pass == 0);
            send(1'b0, OP_ADD, 4'd3, 4'd4);
            send(1'b1, OP_ADD, 4'd0, 4'd9);
            send(1'b1, OP_NAND, 4'd6, 4'hF);
            repeat (3) tick();
            res_ready = 1'b1;
            drain();
        end

        // 4: backpressure fills FIFO, one result held
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++)
            send(1'b0, 3'(i), 4'(i + 3), 4'(i + 1));
        repeat (4) tick();
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_res_valid", res_valid, 1);
        tick();
        res_ready = 1'b1;
        send(1'b1, OP_OR, 4'd0, 4'd8);
        drain();

        // 5: all opcodes back to back, one result every 2 cycles
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_NOR, OP_XNOR, OP_XOR, OP_OR, OP_NAND};
        base = res_cyc_log.size();
        for (int i = 0; i < 8; i++) send(1'b0, ops[i], 4'd4, 4'd2);
        drain();
        check("b2b_count", res_cyc_log.size() - base, 8);
        for (int i = base + 1; i < res_cyc_log.size(); i++)
            check("b2b_spacing", res_cyc_log[i] - res_cyc_log[i-1], 2);

        // 6: reset during ISSUE with two commands still queued
        res_ready = 1'b0;
        send(1'b0, OP_ADD, 4'd1, 4'd1);
        send(1'b0, OP_ADD, 4'd2, 4'd5);
        send(1'b0, OP_XOR, 4'd7, 4'd1);
        send(1'b0, OP_OR, 4'd1, 4'd2);
        repeat (3) tick();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        acc_m = '0;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready_after", in_ready, 1);
        n_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid) n_seen++;
            @(negedge clk);
        end
        check("rst_mid_no_result", n_seen, 0);
        tick();
        send(1'b1, OP_ADD, 4'd7, 4'd1);
        drain();

        // random traffic with random consumer stalls
        rand_rdy = 1;
        for (int i = 0; i < 120; i++) begin
            c.use_acc = 1'($urandom_range(0, 1));
            c.sel = 3'($urandom_range(0, 7));
            c.a = 4'($urandom_range(0, 15));
            c.b = 4'($urandom_range(0, 15));
            send(c.use_acc, c.sel, c.a, c.b);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        rand_rdy = 0;
        res_ready = 1'b1;
        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
